// File: rtl/gs232c_initram.sv
// gs232c_initram: register-based 2^N x W RAM for the cache tag/valid arrays.
//
// The block is the receiving end of the RAM-init sweep. While a sweep is in
// progress every swept entry is cleared to INIT_VALUE and the sweep order is
// checked. Read and write traffic is refused until a sweep ending at the
// all-ones index has completed. After that the array serves one read and one
// write per cycle. Reads have one cycle of latency, and a write in the same
// cycle to the same index is bypassed to the read.
//
// Ports
//   clock       in   clock; all state updates on the rising edge
//   reset       in   synchronous, active-high reset
//   init_valid  in   a sweep entry is present this cycle
//   init_index  in   [N] entry being swept
//   init_done   out  array fully initialised; traffic accepted
//   init_err    out  sticky; sweep arrived out of order
//   rd_req      in   read request
//   rd_index    in   [N] read address
//   rd_ready    out  read accepted this cycle
//   rd_rvalid   out  read data valid, one cycle after acceptance
//   rd_data     out  [W] read data
//   wr_req      in   write request
//   wr_index    in   [N] write address
//   wr_data     in   [W] write data
//   wr_ready    out  write accepted this cycle
module gs232c_initram #(
    parameter int              N          = 6,
    parameter int              W          = 8,
    parameter logic [W-1:0]    INIT_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init_valid,
    input  logic [N-1:0]     init_index,
    output logic             init_done,
    output logic             init_err,
    input  logic             rd_req,
    input  logic [N-1:0]     rd_index,
    output logic             rd_ready,
    output logic             rd_rvalid,
    output logic [W-1:0]     rd_data,
    input  logic             wr_req,
    input  logic [N-1:0]     wr_index,
    input  logic [W-1:0]     wr_data,
    output logic             wr_ready
);

    localparam int          DEPTH      = 1 << N;
    localparam logic [N-1:0] LAST_INDEX = '1;
    localparam logic [N-1:0] ONE_INDEX  = N'(1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   expect_q, expect_d;
    logic           init_err_q, init_err_d;
    logic           rd_rvalid_q, rd_rvalid_d;
    logic [W-1:0]   rd_data_q, rd_data_d;
    logic [W-1:0]   mem_q [DEPTH];

    logic           ready;
    logic           rd_en;
    logic           wr_en;

    // init_done is simply "in READY": the state register and the flag would
    // always change on the same edge, so one flop serves both.
    assign ready     = (state_q == ST_READY);
    assign rd_en     = ready & rd_req;
    assign wr_en     = ready & wr_req;

    assign init_done = ready;
    assign init_err  = init_err_q;
    assign rd_ready  = ready;
    assign wr_ready  = ready;
    assign rd_rvalid = rd_rvalid_q;
    assign rd_data   = rd_data_q;

    // Next-state logic for the control FSM and the read pipeline register.
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        init_err_d  = init_err_q;
        rd_rvalid_d = 1'b0;
        rd_data_d   = rd_data_q;

        // The read returns the array as it stands after this edge. An init
        // write wins over a user write, which wins over the stored value.
        if (rd_en) begin
            rd_rvalid_d = 1'b1;
            if (init_valid && (init_index == rd_index)) begin
                rd_data_d = INIT_VALUE;
            end else if (wr_req && (wr_index == rd_index)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_index];
            end
        end

        case (state_q)
            ST_INIT: begin
                if (init_valid) begin
                    if (init_index == expect_q) begin
                        expect_d = expect_q + ONE_INDEX;
                    end else begin
                        // Resynchronise to the received index so that a single
                        // displaced entry does not flag the rest of the sweep.
                        init_err_d = 1'b1;
                        expect_d   = init_index + ONE_INDEX;
                    end
                    if (init_index == LAST_INDEX) begin
                        state_d  = ST_READY;
                        expect_d = '0;
                    end
                end
            end
            ST_READY: begin
                if (init_valid) begin
                    if (init_index == '0) begin
                        // A new sweep starting; entry 0 counts as received.
                        state_d  = ST_INIT;
                        expect_d = ONE_INDEX;
                    end else begin
                        init_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            expect_q    <= '0;
            init_err_q  <= 1'b0;
            rd_rvalid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            expect_q    <= expect_d;
            init_err_q  <= init_err_d;
            rd_rvalid_q <= rd_rvalid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage array: contents are not reset, the sweep defines them. Each
    // entry decodes its own write enables; the init write takes priority.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (!reset) begin
                    if (init_valid && (init_index == N'(gi))) begin
                        mem_q[gi] <= INIT_VALUE;
                    end else if (wr_en && (wr_index == N'(gi))) begin
                        mem_q[gi] <= wr_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_gs232c_initram.sv
// Self-checking bench for gs232c_initram (N=6, W=8, INIT_VALUE=0).
// Expected read data is pushed to a scoreboard queue when a read is accepted
// and popped when rd_rvalid is seen.
module tb_gs232c_initram;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       init_valid = 1'b0;
    logic [5:0] init_index = '0;
    logic       init_done;
    logic       init_err;
    logic       rd_req = 1'b0;
    logic [5:0] rd_index = '0;
    logic       rd_ready;
    logic       rd_rvalid;
    logic [7:0] rd_data;
    logic       wr_req = 1'b0;
    logic [5:0] wr_index = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;

    int         total = 0;
    int         bad   = 0;

    logic [7:0] mdl [64];
    logic       mdl_done = 1'b0;
    logic [7:0] sb [$];

    gs232c_initram #(.N(6), .W(8), .INIT_VALUE(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .init_valid (init_valid),
        .init_index (init_index),
        .init_done  (init_done),
        .init_err   (init_err),
        .rd_req     (rd_req),
        .rd_index   (rd_index),
        .rd_ready   (rd_ready),
        .rd_rvalid  (rd_rvalid),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle with the currently driven inputs. Ready flags are
    // checked before the edge, rvalid/data/done after it.
    task automatic cycle();
        logic exp_rv;
        logic done_next;
        logic [7:0] exp_d;
        chk("rd_ready", {31'b0, rd_ready}, {31'b0, mdl_done});
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, mdl_done});
        exp_rv    = mdl_done && rd_req;
        done_next = mdl_done;
        if (mdl_done && wr_req) mdl[wr_index] = wr_data;
        if (init_valid) begin
            mdl[init_index] = 8'h00;
            if (!mdl_done && init_index == 6'd63) done_next = 1'b1;
            if (mdl_done && init_index == 6'd0) done_next = 1'b0;
        end
        if (exp_rv) sb.push_back(mdl[rd_index]);
        @(posedge clock);
        #1;
        mdl_done = done_next;
        chk("rd_rvalid", {31'b0, rd_rvalid}, {31'b0, exp_rv});
        chk("init_done", {31'b0, init_done}, {31'b0, mdl_done});
        if (rd_rvalid === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_pending observed=rvalid expected=no_read_outstanding");
            end
            if (sb.size() > 0) begin
                exp_d = sb.pop_front();
                chk("rd_data", {24'b0, rd_data}, {24'b0, exp_d});
                $display("read idx=%0d data=%02h expected=%02h", rd_index, rd_data, exp_d);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; init_valid = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mdl_done = 1'b0;
        sb.delete();
        chk("rst_done",   {31'b0, init_done}, 32'd0);
        chk("rst_err",    {31'b0, init_err},  32'd0);
        chk("rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
        chk("rst_data",   {24'b0, rd_data},   32'd0);
        $display("reset applied");
    endtask

    // Sweep indices 0..last; swap23 sends 0,1,3,2,4.. instead.
    task automatic sweep(input int last, input bit swap23);
        int idx;
        for (int i = 0; i <= last; i++) begin
            idx = i;
            if (swap23 && i == 2) idx = 3;
            if (swap23 && i == 3) idx = 2;
            init_valid = 1'b1;
            init_index = 6'(idx);
            cycle();
            if (i == 1) chk("err_early", {31'b0, init_err}, 32'd0);
            if (swap23 && i == 2) chk("err_after3", {31'b0, init_err}, 32'd1);
        end
        init_valid = 1'b0;
        $display("sweep to %0d swap=%0d done=%0b err=%0b", last, swap23, init_done, init_err);
    endtask

    task automatic rd(input logic [5:0] idx);
        rd_req = 1'b1; rd_index = idx;
        cycle();
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [7:0] d);
        wr_req = 1'b1; wr_index = idx; wr_data = d;
        cycle();
        wr_req = 1'b0;
    endtask

    initial begin
        do_reset();

        // Traffic before init is refused.
        rd_req = 1'b1; rd_index = 6'd5;
        wr_req = 1'b1; wr_index = 6'd5; wr_data = 8'hAA;
        cycle();
        rd_req = 1'b0; wr_req = 1'b0;
        cycle();

        sweep(63, 1'b0);
        chk("done_after_sweep", {31'b0, init_done}, 32'd1);
        chk("err_clean",        {31'b0, init_err},  32'd0);
        rd(6'd0);
        rd(6'd17);
        rd(6'd63);
        rd(6'd5);

        // Same-cycle write/read bypass.
        rd_req = 1'b1; rd_index = 6'd9;
        wr_req = 1'b1; wr_index = 6'd9; wr_data = 8'h5C;
        cycle();
        rd_req = 1'b0; wr_req = 1'b0;
        rd(6'd9);
        cycle();
        chk("rd_hold", {24'b0, rd_data}, 32'h5C);

        // Re-init with a same-cycle write and read of index 0.
        wr(6'd20, 8'h77);
        rd(6'd20);
        init_valid = 1'b1; init_index = 6'd0;
        rd_req = 1'b1; rd_index = 6'd0;
        wr_req = 1'b1; wr_index = 6'd0; wr_data = 8'h33;
        cycle();
        rd_req = 1'b0; wr_req = 1'b0; init_valid = 1'b0;
        chk("reinit_drop", {31'b0, init_done}, 32'd0);
        // Requests during the re-sweep are ignored.
        rd_req = 1'b1; rd_index = 6'd20; wr_req = 1'b1; wr_index = 6'd20; wr_data = 8'h99;
        cycle();
        rd_req = 1'b0; wr_req = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            init_valid = 1'b1; init_index = 6'(i);
            cycle();
        end
        init_valid = 1'b0;
        chk("reinit_done", {31'b0, init_done}, 32'd1);
        chk("reinit_err",  {31'b0, init_err},  32'd0);
        rd(6'd20);
        rd(6'd0);

        // Out-of-order sweep.
        do_reset();
        sweep(63, 1'b1);
        chk("ooo_done", {31'b0, init_done}, 32'd1);
        chk("ooo_err",  {31'b0, init_err},  32'd1);
        wr(6'd40, 8'h11);
        rd(6'd40);
        // Nonzero init in READY: error, entry cleared, stays ready.
        init_valid = 1'b1; init_index = 6'd40;
        cycle();
        init_valid = 1'b0;
        chk("stray_err", {31'b0, init_err}, 32'd1);
        rd(6'd40);
        cycle();
        chk("err_sticky", {31'b0, init_err}, 32'd1);

        // Reset in the middle of a sweep, then a clean sweep.
        do_reset();
        sweep(29, 1'b0);
        do_reset();
        sweep(63, 1'b0);
        chk("fresh_err", {31'b0, init_err}, 32'd0);
        wr(6'd33, 8'hC3);
        rd(6'd33);
        rd(6'd63);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
